// File: rtl/comp_seq.sv
// Digit-serial MSB-first magnitude comparator (signed/unsigned) with start/busy/done handshake.
// Optional min_out/max_out ports are enabled by defining CMP_MINMAX_EN.
module comp_seq #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             eq,
    output logic             gt,
    output logic             lt
`ifdef CMP_MINMAX_EN
    ,
    output logic [WIDTH-1:0] min_out,
    output logic [WIDTH-1:0] max_out
`endif
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    generate
        if (WIDTH < 2 || (WIDTH % DIGIT) != 0) begin : g_bad_params
            $error("comp_seq: WIDTH must be >= 2 and a multiple of DIGIT");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic [CW-1:0]    cnt;
    logic             decided;
    logic             gt_i;
    logic             lt_i;
`ifdef CMP_MINMAX_EN
    logic [WIDTH-1:0] orig_a;
    logic [WIDTH-1:0] orig_b;
`endif

    logic [WIDTH-1:0] offset;
    logic [DIGIT-1:0] dig_a;
    logic [DIGIT-1:0] dig_b;
    logic             dig_gt;
    logic             dig_lt;
    logic             nxt_decided;
    logic             nxt_gt;
    logic             nxt_lt;

    // Flipping the sign bit maps two's complement onto offset binary, so one unsigned scan serves both modes.
    assign offset      = signed_mode ? {1'b1, {(WIDTH-1){1'b0}}} : '0;
    assign dig_a       = sh_a[WIDTH-1 -: DIGIT];
    assign dig_b       = sh_b[WIDTH-1 -: DIGIT];
    assign dig_gt      = dig_a > dig_b;
    assign dig_lt      = dig_a < dig_b;
    assign nxt_decided = decided | dig_gt | dig_lt;
    assign nxt_gt      = decided ? gt_i : dig_gt;
    assign nxt_lt      = decided ? lt_i : dig_lt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            eq      <= 1'b0;
            gt      <= 1'b0;
            lt      <= 1'b0;
            cnt     <= '0;
            sh_a    <= '0;
            sh_b    <= '0;
            decided <= 1'b0;
            gt_i    <= 1'b0;
            lt_i    <= 1'b0;
`ifdef CMP_MINMAX_EN
            orig_a  <= '0;
            orig_b  <= '0;
            min_out <= '0;
            max_out <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        sh_a    <= a ^ offset;
                        sh_b    <= b ^ offset;
                        decided <= 1'b0;
                        gt_i    <= 1'b0;
                        lt_i    <= 1'b0;
                        cnt     <= '0;
                        busy    <= 1'b1;
                        state   <= RUN;
`ifdef CMP_MINMAX_EN
                        orig_a  <= a;
                        orig_b  <= b;
`endif
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    decided <= nxt_decided;
                    gt_i    <= nxt_gt;
                    lt_i    <= nxt_lt;
                    sh_a    <= sh_a << DIGIT;
                    sh_b    <= sh_b << DIGIT;
                    // The final digit's verdict is folded in combinationally so flags land with done.
                    if (cnt == CW'(N - 1)) begin
                        cnt   <= '0;
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        eq    <= ~nxt_decided;
                        gt    <= nxt_gt;
                        lt    <= nxt_lt;
`ifdef CMP_MINMAX_EN
                        min_out <= nxt_gt ? orig_b : orig_a;
                        max_out <= nxt_lt ? orig_b : orig_a;
`endif
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_comp_seq.sv
// Self-checking bench for comp_seq: 8-bit/2-bit instance against a cycle model, plus a 16-bit/4-bit instance.
// Exercises the optional min/max outputs when CMP_MINMAX_EN is defined.
module tb_comp_seq;

    localparam int N8  = 4;
    localparam int N16 = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        signed_mode = 1'b0;
    logic [7:0]  a = '0;
    logic [7:0]  b = '0;
    logic        busy, done, eq, gt, lt;

    logic        s16_start = 1'b0;
    logic        s16_sm = 1'b0;
    logic [15:0] s16_a = '0;
    logic [15:0] s16_b = '0;
    logic        busy16, done16, eq16, gt16, lt16;

`ifdef CMP_MINMAX_EN
    logic [7:0]  min_out, max_out;
    logic [15:0] min16, max16;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    comp_seq #(.WIDTH(8), .DIGIT(2)) dut (
        .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode),
        .a(a), .b(b), .busy(busy), .done(done), .eq(eq), .gt(gt), .lt(lt)
`ifdef CMP_MINMAX_EN
        , .min_out(min_out), .max_out(max_out)
`endif
    );

    comp_seq #(.WIDTH(16), .DIGIT(4)) dut16 (
        .clk(clk), .rst(rst), .start(s16_start), .signed_mode(s16_sm),
        .a(s16_a), .b(s16_b), .busy(busy16), .done(done16), .eq(eq16), .gt(gt16), .lt(lt16)
`ifdef CMP_MINMAX_EN
        , .min_out(min16), .max_out(max16)
`endif
    );

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference ordering from plain integer arithmetic on the operand values.
    function automatic void refCompare(input logic [15:0] x, input logic [15:0] y, input logic sm,
                                       input int w, output logic e, output logic g, output logic l);
        longint vx = longint'(x);
        longint vy = longint'(y);
        if (sm && x[w-1]) vx = vx - (longint'(1) << w);
        if (sm && y[w-1]) vy = vy - (longint'(1) << w);
        e = (vx == vy);
        g = (vx > vy);
        l = (vx < vy);
    endfunction

    logic       armed = 1'b0;
    logic       active = 1'b0;
    int         remaining = 0;
    logic       exp_busy = 1'b0, exp_done = 1'b0, exp_eq = 1'b0, exp_gt = 1'b0, exp_lt = 1'b0;
    logic       pend_eq, pend_gt, pend_lt;
    logic [7:0] pend_a, pend_b;
    logic [7:0] exp_min = '0, exp_max = '0;

    always @(posedge clk) begin
        armed = 1'b1;
        if (rst) begin
            active   = 1'b0;
            exp_busy = 1'b0;
            exp_done = 1'b0;
            exp_eq   = 1'b0;
            exp_gt   = 1'b0;
            exp_lt   = 1'b0;
            exp_min  = '0;
            exp_max  = '0;
        end else begin
            exp_done = 1'b0;
            if (active) begin
                remaining--;
                if (remaining == 0) begin
                    active   = 1'b0;
                    exp_done = 1'b1;
                    exp_eq   = pend_eq;
                    exp_gt   = pend_gt;
                    exp_lt   = pend_lt;
                    exp_min  = pend_lt ? pend_a : (pend_gt ? pend_b : pend_a);
                    exp_max  = pend_gt ? pend_a : (pend_lt ? pend_b : pend_a);
                end
            end else if (start) begin
                active    = 1'b1;
                remaining = N8;
                pend_a    = a;
                pend_b    = b;
                refCompare({8'h00, a}, {8'h00, b}, signed_mode, 8, pend_eq, pend_gt, pend_lt);
            end
            exp_busy = active;
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            checkOutput("cyc_busy", 64'(busy), 64'(exp_busy));
            checkOutput("cyc_done", 64'(done), 64'(exp_done));
            checkOutput("cyc_eq", 64'(eq), 64'(exp_eq));
            checkOutput("cyc_gt", 64'(gt), 64'(exp_gt));
            checkOutput("cyc_lt", 64'(lt), 64'(exp_lt));
`ifdef CMP_MINMAX_EN
            checkOutput("cyc_min", 64'(min_out), 64'(exp_min));
            checkOutput("cyc_max", 64'(max_out), 64'(exp_max));
`endif
        end
    end

    task automatic applyStimulus(input logic [7:0] ta, input logic [7:0] tb, input logic sm);
        a           = ta;
        b           = tb;
        signed_mode = sm;
        start       = 1'b1;
    endtask

    task automatic waitDone(output int k);
        k = 0;
        while (done !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic runOp(input logic [7:0] ta, input logic [7:0] tb, input logic sm,
                         input logic xe, input logic xg, input logic xl, input string tag);
        int k;
        int busy_cnt;
        applyStimulus(ta, tb, sm);
        @(negedge clk);
        start    = 1'b0;
        busy_cnt = (busy === 1'b1) ? 1 : 0;
        k        = 0;
        while (done !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
            if (busy === 1'b1) busy_cnt++;
        end
        checkOutput({tag, "_latency"}, 64'(k), 64'(N8));
        checkOutput({tag, "_busycycles"}, 64'(busy_cnt), 64'(N8));
        checkOutput({tag, "_eq"}, 64'(eq), 64'(xe));
        checkOutput({tag, "_gt"}, 64'(gt), 64'(xg));
        checkOutput({tag, "_lt"}, 64'(lt), 64'(xl));
        @(negedge clk);
        checkOutput({tag, "_donepulse"}, 64'(done), 64'(0));
    endtask

    task automatic runOp16(input logic [15:0] ta, input logic [15:0] tb, input logic sm,
                           input logic xe, input logic xg, input logic xl,
                           input logic [15:0] xmin, input logic [15:0] xmax, input string tag);
        int k;
        s16_a     = ta;
        s16_b     = tb;
        s16_sm    = sm;
        s16_start = 1'b1;
        @(negedge clk);
        s16_start = 1'b0;
        k = 0;
        while (done16 !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        checkOutput({tag, "_latency"}, 64'(k), 64'(N16));
        checkOutput({tag, "_eq"}, 64'(eq16), 64'(xe));
        checkOutput({tag, "_gt"}, 64'(gt16), 64'(xg));
        checkOutput({tag, "_lt"}, 64'(lt16), 64'(xl));
`ifdef CMP_MINMAX_EN
        checkOutput({tag, "_min"}, 64'(min16), 64'(xmin));
        checkOutput({tag, "_max"}, 64'(max16), 64'(xmax));
`else
        if (xmin > xmax) $display("[TB] note: %s min above max", tag);
`endif
        @(negedge clk);
    endtask

    initial begin
        int k;
        int done_seen;
        repeat (2) @(negedge clk);
        checkOutput("rst_busy", 64'(busy), 64'(0));
        checkOutput("rst_done", 64'(done), 64'(0));
        checkOutput("rst_flags", 64'({eq, gt, lt}), 64'(0));
        checkOutput("rst16_flags", 64'({busy16, done16, eq16, gt16, lt16}), 64'(0));
        rst = 1'b0;
        @(negedge clk);

        runOp(8'h80, 8'h7F, 1'b0, 1'b0, 1'b1, 1'b0, "u_80_7f");
        runOp(8'h80, 8'h7F, 1'b1, 1'b0, 1'b0, 1'b1, "s_80_7f");
        runOp(8'hFF, 8'h01, 1'b1, 1'b0, 1'b0, 1'b1, "s_ff_01");
        runOp(8'hFF, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0, "u_ff_01");
        runOp(8'hA5, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, "u_eq_a5");
        runOp(8'hA5, 8'hA5, 1'b1, 1'b1, 1'b0, 1'b0, "s_eq_a5");
        runOp(8'h7F, 8'h80, 1'b1, 1'b0, 1'b1, 1'b0, "s_7f_80");
        runOp(8'h40, 8'h41, 1'b0, 1'b0, 1'b0, 1'b1, "u_lsb_digit");

        // Start pulsed mid-run must be ignored; start held in DONE begins the next op.
        applyStimulus(8'h90, 8'h10, 1'b0);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        applyStimulus(8'h00, 8'h10, 1'b0);
        @(negedge clk);
        start = 1'b0;
        waitDone(k);
        checkOutput("midrun_done_seen", 64'(done), 64'(1));
        checkOutput("midrun_gt", 64'(gt), 64'(1));
        applyStimulus(8'h01, 8'h02, 1'b0);
        @(negedge clk);
        start = 1'b0;
        k = 1;
        while (done !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        checkOutput("b2b_period", 64'(k), 64'(N8 + 1));
        checkOutput("b2b_lt", 64'(lt), 64'(1));
        @(negedge clk);

        // Reset on the second RUN cycle abandons the op without a done pulse.
        applyStimulus(8'h33, 8'h22, 1'b0);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abort_busy", 64'(busy), 64'(0));
        checkOutput("abort_flags", 64'({eq, gt, lt}), 64'(0));
        done_seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (done === 1'b1) done_seen++;
        end
        checkOutput("abort_no_done", 64'(done_seen), 64'(0));
        runOp(8'h33, 8'h22, 1'b0, 1'b0, 1'b1, 1'b0, "after_abort");

        runOp16(16'h8000, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b1, 16'h8000, 16'hFFFF, "w16_s_8000_ffff");
        runOp16(16'h0001, 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0, 16'hFFFF, 16'h0001, "w16_s_0001_ffff");
        runOp16(16'h1234, 16'h1234, 1'b0, 1'b1, 1'b0, 1'b0, 16'h1234, 16'h1234, "w16_u_eq");

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "[TB] timeout");
    end

endmodule
